// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers scaled/saturated audio samples in a small FIFO and
// plays one sample per PWM frame on a single-bit output.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   in_sample     16-bit unsigned mixed sample (bits [9:0] meaningful)
//   in_valid      sample present this cycle
//   in_ready      FIFO can accept (registered !full)
//   volume        right-shift applied at push
//   clr_flags     clears the sticky flags
//   pwm_out       registered PWM audio output
//   frame_start   one-cycle pulse on the cnt==0 cycle of each frame
//   fifo_level    entries currently held
//   underrun      sticky: a frame started with the FIFO empty
//   overflow      sticky: in_valid asserted while full
module audio_pwm_out #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    volume,
    input  logic                          clr_flags,
    output logic                          pwm_out,
    output logic                          frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;

    logic [15:0]         shifted_c;
    logic [PWM_BITS-1:0] scaled_c;
    logic                push_c;
    logic                pop_c;
    logic                boundary_c;
    logic [PWM_BITS-1:0] cnt_next_c;
    logic [PWM_BITS-1:0] duty_next_c;
    logic [LVL_W-1:0]    level_next_c;
    logic                underrun_set_c;
    logic                overflow_set_c;

    // Volume shift on the full 16 bits, then saturate to PWM range
    assign shifted_c = in_sample >> volume;

    always_comb begin
        scaled_c = PWM_BITS'(shifted_c);
        if (shifted_c > 16'(CNT_MAX)) begin
            scaled_c = CNT_MAX;
        end
    end

    // Next-state: counter, pop at frame boundary, level bookkeeping, flag sets
    always_comb begin
        push_c         = in_valid & in_ready;
        boundary_c     = (cnt == CNT_MAX);
        pop_c          = boundary_c & (fifo_level != '0);
        cnt_next_c     = cnt + PWM_BITS'(1);
        duty_next_c    = duty;
        level_next_c   = fifo_level;
        underrun_set_c = boundary_c & (fifo_level == '0);
        overflow_set_c = in_valid & ~in_ready;

        if (pop_c) begin
            duty_next_c = mem[rd_ptr];
        end
        if (push_c && !pop_c) begin
            level_next_c = fifo_level + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            level_next_c = fifo_level - LVL_W'(1);
        end
    end

    // Control state; in_ready tracks the post-update level so it is a pure register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            duty        <= '0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            in_ready    <= 1'b1;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            cnt         <= cnt_next_c;
            duty        <= duty_next_c;
            pwm_out     <= (cnt_next_c < duty_next_c);
            frame_start <= (cnt_next_c == '0);
            fifo_level  <= level_next_c;
            in_ready    <= (level_next_c != LVL_W'(FIFO_DEPTH));
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Set wins over a coincident clear
            underrun <= underrun_set_c | (underrun & ~clr_flags);
            overflow <= overflow_set_c | (overflow & ~clr_flags);
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= scaled_c;
        end
    end

endmodule
